// File: rtl/avg_window_if.sv
// rtl/avg_window_if.sv - sample-in / average-out handshake and decade counter strobes
interface avg_window_if #(
    parameter int DATA_W = 8
);
    logic              start;
    logic [2:0]        win_sel;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic              busy;
    logic              cnt_tick;
    logic              cnt_clr;

    modport master (
        output start, win_sel, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy, cnt_tick, cnt_clr
    );

    modport slave (
        input  start, win_sel, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy, cnt_tick, cnt_clr
    );
endinterface

// File: rtl/avg_window_ctrl.sv
// rtl/avg_window_ctrl.sv - 10^k-sample window averager with shared serial divide-by-10
// Optional AVG_ROUND_EN: bias sum by half a window before dividing (round half-up).
module avg_window_ctrl #(
    parameter int DATA_W  = 8,
    parameter int MAX_EXP = 4
) (
    input  logic         clk,
    input  logic         rst,
    avg_window_if.slave  bus
);
    localparam int SUM_W = DATA_W + 14;
    localparam int BIT_W = $clog2(SUM_W);

    typedef enum logic [1:0] {IDLE, ACCUM, DIV, OUT} state_t;

    state_t            state, next_state;
    logic [2:0]        exp_q, sel_exp, pass_q;
    logic [SUM_W-1:0]  sum_q, cnt_q, window, bias, shifted, sample_ext;
    logic [3:0]        rem_q, rem_nxt;
    logic [4:0]        trial;
    logic [BIT_W-1:0]  bit_q;
    logic [DATA_W-1:0] out_q;
    logic              tick_q, clr_q, hs, last, ge, bit_last, pass_last, div_done;

    function automatic logic [SUM_W-1:0] pow10(input logic [2:0] e);
        logic [SUM_W-1:0] p;
        p = SUM_W'(1);
        for (int i = 0; i < 7; i++)
            if (i < int'(e)) p = p * SUM_W'(10);
        return p;
    endfunction

    always_comb begin
        if (bus.win_sel == 3'd0)               sel_exp = 3'd1;
        else if (bus.win_sel > 3'(MAX_EXP))    sel_exp = 3'(MAX_EXP);
        else                                   sel_exp = bus.win_sel;
    end

    assign window     = pow10(exp_q);
`ifdef AVG_ROUND_EN
    assign bias       = window >> 1;
`else
    assign bias       = '0;
`endif
    assign sample_ext = SUM_W'(bus.in_data);
    assign hs         = (state == ACCUM) && bus.in_valid;
    assign last       = hs && ((cnt_q + SUM_W'(1)) == window);

    // One restoring step: bring down the dividend MSB, subtract 10 if it fits.
    assign trial      = {rem_q, sum_q[SUM_W-1]};
    assign ge         = trial >= 5'd10;
    assign rem_nxt    = ge ? 4'(trial - 5'd10) : trial[3:0];
    assign shifted    = {sum_q[SUM_W-2:0], ge};
    assign bit_last   = bit_q == BIT_W'(SUM_W - 1);
    assign pass_last  = pass_q == 3'd1;
    assign div_done   = (state == DIV) && bit_last && pass_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.start)     next_state = ACCUM;
            ACCUM:   if (last)          next_state = DIV;
            DIV:     if (div_done)      next_state = OUT;
            OUT:     if (bus.out_ready) next_state = IDLE;
            default:                    next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q  <= '0;
            sum_q  <= '0;
            cnt_q  <= '0;
            rem_q  <= '0;
            bit_q  <= '0;
            pass_q <= '0;
            out_q  <= '0;
            tick_q <= 1'b0;
            clr_q  <= 1'b0;
        end else begin
            tick_q <= hs;
            clr_q  <= (state == IDLE) && bus.start;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        exp_q <= sel_exp;
                        sum_q <= '0;
                        cnt_q <= '0;
                    end
                end
                ACCUM: begin
                    if (hs) begin
                        cnt_q <= cnt_q + SUM_W'(1);
                        if (last) begin
                            sum_q  <= sum_q + sample_ext + bias;
                            rem_q  <= '0;
                            bit_q  <= '0;
                            pass_q <= exp_q;
                        end else begin
                            sum_q  <= sum_q + sample_ext;
                        end
                    end
                end
                DIV: begin
                    // Quotient bits shift in from the LSB, so sum_q ends each pass as the quotient.
                    sum_q <= shifted;
                    if (bit_last) begin
                        rem_q  <= '0;
                        bit_q  <= '0;
                        pass_q <= pass_q - 3'd1;
                        if (pass_last) out_q <= shifted[DATA_W-1:0];
                    end else begin
                        rem_q  <= rem_nxt;
                        bit_q  <= bit_q + BIT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == ACCUM);
    assign bus.busy      = (state != IDLE);
    assign bus.out_valid = (state == OUT);
    assign bus.out_data  = out_q;
    assign bus.cnt_tick  = tick_q;
    assign bus.cnt_clr   = clr_q;
endmodule
